// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential multi-digit BCD adder: FSM encoding,
// BCD constants and a digit-validity helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  function automatic logic is_bcd_digit(input logic [3:0] i_digit);
    return (i_digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit decimal adder: a + b + cin with the +6 decimal
// correction whenever the binary sum exceeds nine.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_digit,
  output logic       o_cout
);

  logic [4:0] w_raw;
  logic [3:0] w_adj;

  // Only the low nibble of raw+6 is kept, so the correction can be done in 4 bits.
  always_comb begin
    w_raw = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    w_adj = w_raw[3:0] + BCD_ADJ;
    if (w_raw > {1'b0, BCD_MAX}) begin
      o_digit = w_adj;
      o_cout  = 1'b1;
    end else begin
      o_digit = w_raw[3:0];
      o_cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_multidigit_seq.sv
// Adds two packed-BCD operands one digit per clock through a single shared
// digit adder, least-significant digit first, with a start/done handshake.
module bcd_multidigit_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   Addend,
  input  logic [4*DIGITS-1:0]   Augend,
  input  logic                  Carry_in,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Sum,
  output logic                  Carry_out,
  output logic                  Error
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t               r_state;
  state_t               w_next;
  logic [IDX_W-1:0]     r_idx;
  logic [4*DIGITS-1:0]  r_a;
  logic [4*DIGITS-1:0]  r_b;
  logic [4*DIGITS-1:0]  r_acc;
  logic                 r_carry;
  logic                 r_err_cap;
  logic                 r_busy;
  logic                 r_done;
  logic [4*DIGITS-1:0]  r_sum;
  logic                 r_cout;
  logic                 r_error;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_bad;
  logic [3:0]           w_a;
  logic [3:0]           w_b;
  logic [3:0]           w_digit;
  logic                 w_cout;

  assign w_accept = (r_state == ST_IDLE) && Start;
  assign w_last   = (r_idx == IDX_W'(DIGITS - 1));
  assign w_a      = r_a[{r_idx, 2'b00} +: 4];
  assign w_b      = r_b[{r_idx, 2'b00} +: 4];

  // Validity is judged on the live inputs so it is ready on the accepting edge.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(Addend[4*i +: 4]) || !is_bcd_digit(Augend[4*i +: 4])) begin
        w_bad = 1'b1;
      end
    end
  end

  bcd_digit_adder u_digit_adder (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_cin   (r_carry),
    .o_digit (w_digit),
    .o_cout  (w_cout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (Start)  w_next = ST_ADD;
      ST_ADD:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idx     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_err_cap <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_busy <= (r_state == ST_ADD) || (r_state == ST_DONE);
      r_done <= (r_state == ST_DONE);
      if (w_accept) begin
        r_a       <= Addend;
        r_b       <= Augend;
        r_carry   <= Carry_in;
        r_acc     <= '0;
        r_idx     <= '0;
        r_err_cap <= w_bad;
      end
      if (r_state == ST_ADD) begin
        r_acc[{r_idx, 2'b00} +: 4] <= w_digit;
        r_carry                    <= w_cout;
        if (!w_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end
      // Results are published only here, so the outputs never show partial sums.
      if (r_state == ST_DONE) begin
        r_sum   <= r_err_cap ? '0 : r_acc;
        r_cout  <= r_err_cap ? 1'b0 : r_carry;
        r_error <= r_err_cap;
      end
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Sum       = r_sum;
  assign Carry_out = r_cout;
  assign Error     = r_error;

endmodule

// File: tb/tb_bcd_multidigit_seq.sv
// Self-checking bench for bcd_multidigit_seq: decimal-arithmetic reference model
// compared every cycle, plus directed operations with literal expectations.
module tb_bcd_multidigit_seq;

  localparam int D    = 4;
  localparam int W    = 4 * D;
  localparam int MODV = 10 ** D;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] Addend = '0;
  logic [W-1:0] Augend = '0;
  logic         Carry_in = 1'b0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Carry_out;
  logic         Error;

  int errors = 0;
  int checks = 0;

  bcd_multidigit_seq #(.DIGITS(D)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Addend    (Addend),
    .Augend    (Augend),
    .Carry_in  (Carry_in),
    .Busy      (Busy),
    .Done      (Done),
    .Sum       (Sum),
    .Carry_out (Carry_out),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  function automatic logic bcd_bad(input logic [W-1:0] x);
    for (int i = 0; i < D; i++) if (x[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int bcd_val(input logic [W-1:0] x);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int total(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return bcd_val(a) + bcd_val(b) + int'(c);
  endfunction

  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    if (bcd_bad(a) || bcd_bad(b)) return '0;
    return to_bcd(total(a, b, c) % MODV);
  endfunction

  function automatic logic ref_cout(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    if (bcd_bad(a) || bcd_bad(b)) return 1'b0;
    return (total(a, b, c) >= MODV);
  endfunction

  // Reference model: m_p counts edges since acceptance (0 = idle); the result
  // appears D+1 edges after acceptance and a new request is taken on the next edge.
  int           m_p = 0;
  logic [W-1:0] m_pend_sum = '0, m_sum = '0;
  logic         m_pend_cout = 1'b0, m_pend_err = 1'b0;
  logic         m_cout = 1'b0, m_err = 1'b0;
  logic         exp_busy, exp_done;

  assign exp_busy = (m_p >= 2);
  assign exp_done = (m_p == D + 2);

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_p    <= 0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_err  <= 1'b0;
    end else if (m_p == 0 || m_p == D + 2) begin
      if (Start) begin
        m_p         <= 1;
        m_pend_sum  <= ref_sum(Addend, Augend, Carry_in);
        m_pend_cout <= ref_cout(Addend, Augend, Carry_in);
        m_pend_err  <= bcd_bad(Addend) || bcd_bad(Augend);
      end else begin
        m_p <= 0;
      end
    end else begin
      m_p <= m_p + 1;
      if (m_p == D + 1) begin
        m_sum  <= m_pend_sum;
        m_cout <= m_pend_cout;
        m_err  <= m_pend_err;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    check("model busy", 32'(Busy), 32'(exp_busy));
    check("model done", 32'(Done), 32'(exp_done));
    check("model sum", 32'(Sum), 32'(m_sum));
    check("model cout", 32'(Carry_out), 32'(m_cout));
    check("model error", 32'(Error), 32'(m_err));
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] xs, input logic xc, input logic xe,
                        input bit pulse, input string tag);
    int k;
    int busy_n;
    @(negedge Clk);
    Start = 1'b1; Addend = a; Augend = b; Carry_in = c;
    @(negedge Clk);
    Start = 1'b0; Addend = 16'h8765; Augend = 16'h4321; Carry_in = ~c;
    k = 0;
    busy_n = 0;
    do begin
      @(negedge Clk);
      k++;
      if (Busy) busy_n++;
      if (pulse && (k == 2 || k == 4)) begin
        Start = 1'b1; Addend = 16'h1111; Augend = 16'h2222;
      end else begin
        Start = 1'b0;
      end
    end while (!Done && k < 20);
    Start = 1'b0;
    check({tag, " latency"}, 32'(k), 32'(D + 1));
    check({tag, " busy cycles"}, 32'(busy_n), 32'(D + 1));
    check({tag, " sum"}, 32'(Sum), 32'(xs));
    check({tag, " carry_out"}, 32'(Carry_out), 32'(xc));
    check({tag, " error"}, 32'(Error), 32'(xe));
    @(negedge Clk);
    check({tag, " done single"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int cyc;
    int last;
    int ndone;
    bit saw;
    bit prev;

    repeat (3) @(negedge Clk);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset sum", 32'(Sum), 32'd0);
    check("reset cout", 32'(Carry_out), 32'd0);
    check("reset error", 32'(Error), 32'd0);
    Reset_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, "t1");
    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "t2a");
    run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, "t2b");
    run_op(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "t3err");
    run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, "t3ok");
    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1, "t4");

    // Abort during the second ADD cycle.
    @(negedge Clk);
    Start = 1'b1; Addend = 16'h4444; Augend = 16'h3333; Carry_in = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("async busy", 32'(Busy), 32'd0);
    check("async done", 32'(Done), 32'd0);
    check("async sum", 32'(Sum), 32'd0);
    check("async cout", 32'(Carry_out), 32'd0);
    check("async error", 32'(Error), 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (Done) saw = 1'b1;
    end
    check("no done after reset", 32'(saw), 32'd0);
    run_op(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "t5");

    // Start held high: one result every D+2 cycles.
    @(negedge Clk);
    Start = 1'b1; Addend = 16'h0001; Augend = 16'h0002; Carry_in = 1'b0;
    cyc = 0; last = -1; ndone = 0; prev = 1'b0;
    repeat (40) begin
      @(negedge Clk);
      cyc++;
      if (Done) begin
        ndone++;
        check("t6 sum", 32'(Sum), 32'h0003);
        check("t6 no back-to-back done", 32'(prev), 32'd0);
        if (last >= 0) check("t6 period", 32'(cyc - last), 32'(D + 2));
        last = cyc;
      end
      prev = Done;
    end
    Start = 1'b0;
    check("t6 done count", 32'(ndone), 32'd6);

    repeat (3) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_multidigit_seq.md
Name: bcd_multidigit_seq

Overview:
- Multi-cycle controller that adds two DIGITS-wide packed-BCD operands by reusing one single-digit BCD adder, one digit per clock, least-significant digit first.
- Sits between a requester (keypad/calculator datapath) and the shared digit adder.
- Owns operand capture, digit sequencing, carry chaining, input-validity checking and a start/done handshake.

Parameters:
DIGITS, 4, number of BCD digits per operand (1..8); operand width 4*DIGITS.

Ports:
Clk  input  1  single clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Start  input  1  request; sampled only in IDLE.
Addend  input  4*DIGITS  packed BCD operand A, digit 0 in bits [3:0]; captured on accepted Start.
Augend  input  4*DIGITS  packed BCD operand B; captured on accepted Start.
Carry_in  input  1  decimal carry into digit 0; captured on accepted Start.
Busy  output  1  high from the cycle after acceptance until Done is asserted, inclusive.
Done  output  1  one-cycle pulse; Sum, Carry_out and Error are valid from this cycle.
Sum  output  4*DIGITS  packed BCD result; held until the next accepted Start.
Carry_out  output  1  decimal carry out of the top digit; held as Sum.
Error  output  1  high if any captured digit of either operand was greater than 9; held as Sum.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE; Busy=0, Done=0, Sum=0, Carry_out=0, Error=0.
  - Internal operand, carry and index registers cleared.
  - A reset mid-operation abandons the sum; no Done is produced.
- States:
  - IDLE: Start=1 latches Addend, Augend, Carry_in; clears result shift register; idx=0; Error computed from captured digits; -> ADD.
  - ADD: one digit per cycle.
    - Digit adder inputs: A[idx], B[idx], carry register.
    - Digit sum goes to Sum[idx]; digit carry goes to the carry register.
    - idx==DIGITS-1 -> DONE, else idx++.
  - DONE: Done=1 for exactly this cycle; Carry_out=carry register; -> IDLE.
- Latency: Start sampled at edge 0 -> Done high after edge DIGITS+1. Busy high for DIGITS+1 cycles. Back-to-back throughput is one operation per DIGITS+2 cycles.
- Digit-adder rule:
  - raw = a+b+c (5 bits).
  - If raw>9: digit=(raw+6)[3:0], carry=1; else digit=raw[3:0], carry=0.
- Error case:
  - Sequencing and latency are unchanged.
  - At DONE, Sum=0 and Carry_out=0 regardless of digit arithmetic.
  - Error=1 until the next accepted Start.
- Start handling:
  - Start in ADD or DONE is ignored; there is no queuing.
  - Start held high continuously re-accepts on every IDLE cycle.
- Operand inputs may change freely after acceptance; only captured copies are used.
- Sum, Carry_out and Error update only on the DONE transition. Intermediate digits sit in an internal register, so outputs never show partial results.

Decomposition:
- Shared package bcd_pkg:
  - state encoding (IDLE=2'd0, ADD=2'd1, DONE=2'd2)
  - BCD_MAX=4'd9
  - BCD_ADJ=4'd6
  - function is_bcd_digit
- Sub-module bcd_digit_adder (combinational, 4-bit a, b, 1-bit cin -> 4-bit digit, cout). Instantiated once, muxed by idx.
- FSM, index counter and registers live in bcd_multidigit_seq.

Test Plan:
1. DIGITS=4, Addend=16'h1234, Augend=16'h5678, Carry_in=0, Start 1 cycle -> Done exactly 5 cycles after the accepting edge, Sum=16'h6912, Carry_out=0, Error=0, Busy high 5 cycles.
2. 16'h9999 + 16'h0001, Carry_in=0 -> Sum=16'h0000, Carry_out=1. Then 16'h9999 + 16'h9999, Carry_in=1 -> Sum=16'h9999, Carry_out=1.
3. Addend=16'h12A4, Augend=16'h0001 -> Done at the same latency, Error=1, Sum=0, Carry_out=0. A following valid op 16'h0005+16'h0005 -> Sum=16'h0010, Error=0.
4. Start pulsed in ADD with different operands -> ignored; first result 16'h6912 unchanged; no extra Done.
5. Reset_n dropped during the second ADD cycle -> all outputs 0 immediately (async); no Done after release; a new Start computes correctly.
6. Start held high with constant operands 0001+0002 -> Done pulses every 6 cycles, Sum=16'h0003 each time, Done never high two consecutive cycles.
